// File: rtl/prim_reg_slice.sv
// Two-entry valid/ready register slice (skid buffer).
// Registers both the forward path (valid/data) and the backward path
// (ready) so that neither side sees a combinational path through the
// slice. Full throughput is preserved because the skid entry absorbs
// the one beat that arrives while the consumer stalls, before the
// registered ready reaches the producer.

module prim_reg_slice #(
  parameter int unsigned      Width      = 32,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o
);

  // Occupancy: how many of the two registers hold live entries.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StTwo   = 2'd2
  } state_e;

  state_e           state_q;
  logic [Width-1:0] main_q;
  logic [Width-1:0] skid_q;

  logic inXfer;
  logic outXfer;

  // Handshake outputs are decoded from the state register only, so no
  // input reaches an output combinationally.
  assign valid_o = (state_q != StEmpty);
  assign ready_o = (state_q != StTwo);
  assign data_o  = main_q;

  assign inXfer  = valid_i & ready_o;
  assign outXfer = valid_o & ready_i;

  // Occupancy FSM together with the main and skid data registers.
  // Flush only empties the state; register contents are left alone so
  // data_o keeps showing the last value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      main_q  <= ResetValue;
      skid_q  <= ResetValue;
    end else if (flush_i) begin
      state_q <= StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (inXfer) begin
            main_q  <= data_i;
            state_q <= StOne;
          end
        end
        StOne: begin
          if (inXfer && outXfer) begin
            main_q <= data_i;
          end else if (inXfer) begin
            skid_q  <= data_i;
            state_q <= StTwo;
          end else if (outXfer) begin
            state_q <= StEmpty;
          end
        end
        StTwo: begin
          if (outXfer) begin
            main_q  <= skid_q;
            state_q <= StOne;
          end
        end
        default: begin
          state_q <= StEmpty;
        end
      endcase
    end
  end

  // A presented beat must stay presented until the consumer takes it.
  validHoldA : assert property (
    @(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i && !flush_i) |=> valid_o
  );

  // Presented data must never be X.
  dataKnownA : assert property (
    @(posedge clk_i) disable iff (rst_i)
    valid_o |-> !$isunknown(data_o)
  );

endmodule

// File: tb/tb_prim_reg_slice.sv
// Directed and randomized-stall bench for prim_reg_slice.
// Inputs change 1 time unit after each rising edge and outputs are
// sampled at that same point, away from the active edge.

module tb_prim_reg_slice;

  localparam int unsigned      Width = 32;
  localparam logic [Width-1:0] RstVal = 32'hDEAD_BEEF;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             validIn;
  logic             readyOut;
  logic [Width-1:0] dataIn;
  logic             validOut;
  logic             readyIn;
  logic [Width-1:0] dataOut;

  int checkCount;
  int errorCount;

  logic [Width-1:0] modelQ[$];

  prim_reg_slice #(
    .Width      (Width),
    .ResetValue (RstVal)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .valid_i (validIn),
    .ready_o (readyOut),
    .data_i  (dataIn),
    .valid_o (validOut),
    .ready_i (readyIn),
    .data_o  (dataOut)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [Width-1:0] observed,
                             input logic [Width-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then advance past the next rising edge.
  task automatic applyStimulus(input logic r, input logic f, input logic v,
                               input logic [Width-1:0] d, input logic rdy);
    rst     = r;
    flush   = f;
    validIn = v;
    dataIn  = d;
    readyIn = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int drainCycles;
    logic expValid;
    logic expReady;
    logic inX;
    logic outX;
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1; flush = 1'b0; validIn = 1'b0; dataIn = '0; readyIn = 1'b0;

    // Reset held for two cycles with valid_i asserted.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h5555_5555, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h5555_5555, 1'b0);
    rst = 1'b0; validIn = 1'b0;
    checkOutput("rst_valid", {31'd0, validOut}, 32'd0);
    checkOutput("rst_ready", {31'd0, readyOut}, 32'd1);
    checkOutput("rst_data", dataOut, RstVal);

    // Streaming 1..100 with no stalls: each beat visible one cycle later.
    for (int i = 1; i <= 100; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, i, 1'b1);
      checkOutput("stream_valid", {31'd0, validOut}, 32'd1);
      checkOutput("stream_data", dataOut, i);
      checkOutput("stream_ready", {31'd0, readyOut}, 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("stream_end_valid", {31'd0, validOut}, 32'd0);
    checkOutput("stream_end_data", dataOut, 32'd100);

    // Backpressure: A then B fill both entries, C is held off.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hA, 1'b0);
    checkOutput("bp_a_valid", {31'd0, validOut}, 32'd1);
    checkOutput("bp_a_data", dataOut, 32'hA);
    checkOutput("bp_a_ready", {31'd0, readyOut}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hB, 1'b0);
    checkOutput("bp_b_ready", {31'd0, readyOut}, 32'd0);
    checkOutput("bp_b_data", dataOut, 32'hA);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hC, 1'b0);
    checkOutput("bp_hold_ready", {31'd0, readyOut}, 32'd0);
    checkOutput("bp_hold_valid", {31'd0, validOut}, 32'd1);
    checkOutput("bp_hold_data", dataOut, 32'hA);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
    checkOutput("bp_out_b", dataOut, 32'hB);
    checkOutput("bp_out_b_ready", {31'd0, readyOut}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hC, 1'b1);
    checkOutput("bp_out_c", dataOut, 32'hC);
    checkOutput("bp_out_c_valid", {31'd0, validOut}, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("bp_drained", {31'd0, validOut}, 32'd0);

    // Random stall traffic against a reference queue.
    for (int c = 0; c < 10000; c++) begin
      validIn = ($urandom_range(0, 1) == 1);
      readyIn = ($urandom_range(0, 1) == 1);
      dataIn  = $urandom;
      expValid = (modelQ.size() != 0);
      expReady = (modelQ.size() < 2);
      checkOutput("rand_valid", {31'd0, validOut}, {31'd0, expValid});
      checkOutput("rand_ready", {31'd0, readyOut}, {31'd0, expReady});
      inX  = validIn && expReady;
      outX = expValid && readyIn;
      if (outX) begin
        checkOutput("rand_data", dataOut, modelQ[0]);
        void'(modelQ.pop_front());
      end
      if (inX) modelQ.push_back(dataIn);
      applyStimulus(1'b0, 1'b0, validIn, dataIn, readyIn);
    end
    drainCycles = 0;
    while (modelQ.size() != 0 && drainCycles < 10) begin
      if (validOut) begin
        checkOutput("drain_data", dataOut, modelQ[0]);
        void'(modelQ.pop_front());
      end else begin
        checkOutput("drain_valid", {31'd0, validOut}, 32'd1);
        modelQ.delete();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
      drainCycles++;
    end
    checkOutput("drain_empty", modelQ.size(), 32'd0);
    checkOutput("drain_valid_low", {31'd0, validOut}, 32'd0);

    // Flush while full, with a coincident (blocked) beat 0x33.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h11, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h22, 1'b0);
    checkOutput("fl_full_ready", {31'd0, readyOut}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h33, 1'b0);
    checkOutput("fl_valid", {31'd0, validOut}, 32'd0);
    checkOutput("fl_ready", {31'd0, readyOut}, 32'd1);
    checkOutput("fl_data_kept", dataOut, 32'h11);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h44, 1'b0);
    checkOutput("fl_next_valid", {31'd0, validOut}, 32'd1);
    checkOutput("fl_next_data", dataOut, 32'h44);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("fl_only_one", {31'd0, validOut}, 32'd0);

    // Reset while full with the consumer ready.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h55, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h66, 1'b0);
    checkOutput("mr_full_ready", {31'd0, readyOut}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("mr_valid", {31'd0, validOut}, 32'd0);
    checkOutput("mr_ready", {31'd0, readyOut}, 32'd1);
    checkOutput("mr_data", dataOut, RstVal);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("mr_stays_empty", {31'd0, validOut}, 32'd0);
    checkOutput("mr_data_hold", dataOut, RstVal);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
